// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-setting controller for the calendar clock.
// Mode key steps through the settable fields. Up/down keys pulse the
// selected counter. Timekeeping is frozen while a field is selected,
// and an idle timeout returns the block to RUN.
// Optional build macro: SET_AUTOREPEAT_EN enables hold-to-repeat on up/down.
// Auto-repeat assumes RPT_CYC <= HOLD_CYC (repeat reuses the hold counter).
module clock_set_ctrl #(
  parameter int HOLD_CYC    = 50_000_000,
  parameter int RPT_CYC     = 10_000_000,
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_en,
  input  logic       mode_btn,
  input  logic       up_btn,
  input  logic       down_btn,
  output logic       run_tick,
  output logic [2:0] field_sel,
  output logic       set_up,
  output logic       set_down,
  output logic       setting
);

  typedef enum logic [2:0] {
    RUN  = 3'd0,
    SEC  = 3'd1,
    MIN  = 3'd2,
    HOUR = 3'd3,
    DAY  = 3'd4,
    MON  = 3'd5,
    YR   = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic             mode_q, up_q, down_q;
  logic             armed;
  logic             mode_e, up_e, down_e;
  logic             in_set;
  logic [CNT_W-1:0] to_cnt;
  logic             to_clr, to_hit;
  logic             up_p, dn_p;
  logic             rep_up, rep_dn;
  logic             up_d, dn_d;

  // armed stays low for the first cycle after reset, so a key that is
  // already held when reset releases never registers as a press.
  assign mode_e = armed & mode_btn & ~mode_q;
  assign up_e   = armed & up_btn   & ~up_q;
  assign down_e = armed & down_btn & ~down_q;

  assign in_set = (state_q != RUN);

  // Any key activity keeps the user in the set state.
  assign to_clr = mode_e | up_e | down_e | up_btn | down_btn;
  assign to_hit = in_set & ~to_clr & (to_cnt == TO_LAST);

  // Single-step pulses: a lone press in a set state; mode wins a collision.
  assign up_p = in_set & ~mode_e & up_e   & ~down_e;
  assign dn_p = in_set & ~mode_e & down_e & ~up_e;

  // Previous key levels for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
      up_q   <= 1'b0;
      down_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      mode_q <= mode_btn;
      up_q   <= up_btn;
      down_q <= down_btn;
      armed  <= 1'b1;
    end
  end

  // Field-select state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Next field: mode advances cyclically, idle timeout drops back to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     state_d = mode_e ? SEC  : RUN;
      SEC:     state_d = mode_e ? MIN  : SEC;
      MIN:     state_d = mode_e ? HOUR : MIN;
      HOUR:    state_d = mode_e ? DAY  : HOUR;
      DAY:     state_d = mode_e ? MON  : DAY;
      MON:     state_d = mode_e ? YR   : MON;
      YR:      state_d = mode_e ? RUN  : YR;
      default: state_d = RUN;
    endcase
    if (!mode_e && to_hit) state_d = RUN;
  end

  // Idle timeout counter: only runs in set states with no key activity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             to_cnt <= '0;
    else if (!in_set || to_clr || to_hit) to_cnt <= '0;
    else                                 to_cnt <= to_cnt + 1'b1;
  end

`ifdef SET_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(HOLD_CYC - RPT_CYC);

  logic             rpt_act, rpt_dir;
  logic [CNT_W-1:0] hold_cnt;
  logic             rpt_start, rpt_keep, rpt_fire;

  // Repeat arms on a press of one key while the other is released, and
  // survives only while that same key alone stays held in the same field.
  assign rpt_start = in_set & ~mode_e & ((up_e & ~down_btn) | (down_e & ~up_btn));
  assign rpt_keep  = rpt_act & in_set & ~mode_e &
                     (rpt_dir ? (up_btn & ~down_btn) : (down_btn & ~up_btn));
  assign rpt_fire  = rpt_keep & (hold_cnt == HOLD_LAST);
  assign rep_up    = rpt_fire &  rpt_dir;
  assign rep_dn    = rpt_fire & ~rpt_dir;

  // Hold counter: first fire after HOLD_CYC, then reload so the next fire
  // lands RPT_CYC cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_act  <= 1'b0;
      rpt_dir  <= 1'b0;
      hold_cnt <= '0;
    end else if (rpt_start) begin
      rpt_act  <= 1'b1;
      rpt_dir  <= up_e;
      hold_cnt <= '0;
    end else if (rpt_keep) begin
      hold_cnt <= rpt_fire ? RPT_RELOAD : hold_cnt + 1'b1;
    end else begin
      rpt_act  <= 1'b0;
      hold_cnt <= '0;
    end
  end
`else
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif

  assign up_d = up_p | rep_up;
  assign dn_d = (dn_p | rep_dn) & ~up_d;

  // Registered one-cycle set pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_up   <= 1'b0;
      set_down <= 1'b0;
    end else begin
      set_up   <= up_d;
      set_down <= dn_d;
    end
  end

  assign field_sel = state_q;
  assign setting   = in_set;
  assign run_tick  = tick_en & ~in_set;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus a random phase, all
// cycles checked against a behavioural model of the setting rules.
module tb_clock_set_ctrl;
  localparam int HOLD = 20;
  localparam int RPT  = 5;
  localparam int TO   = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_en = 1'b0;
  logic       mode_btn = 1'b0;
  logic       up_btn = 1'b0;
  logic       down_btn = 1'b0;
  logic       run_tick, set_up, set_down, setting;
  logic [2:0] field_sel;

  int total = 0;
  int bad   = 0;

  clock_set_ctrl #(
    .HOLD_CYC(HOLD), .RPT_CYC(RPT), .TIMEOUT_CYC(TO), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .tick_en(tick_en), .mode_btn(mode_btn),
    .up_btn(up_btn), .down_btn(down_btn), .run_tick(run_tick),
    .field_sel(field_sel), .set_up(set_up), .set_down(set_down),
    .setting(setting)
  );

  always #5 clk = ~clk;

  // model state
  int m_field, m_idle;
  bit m_arm, m_pm, m_pu, m_pd, m_up, m_dn;
`ifdef SET_AUTOREPEAT_EN
  int m_rk;
  bit m_dir;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_field = 0; m_idle = 0;
    m_arm = 0; m_pm = 0; m_pu = 0; m_pd = 0; m_up = 0; m_dn = 0;
`ifdef SET_AUTOREPEAT_EN
    m_rk = -1; m_dir = 0;
`endif
  endtask

  task automatic m_step();
    bit me, ue, de, st, nu, nd, clr;
    if (rst) begin
      m_reset();
      return;
    end
    me = m_arm && mode_btn && !m_pm;
    ue = m_arm && up_btn   && !m_pu;
    de = m_arm && down_btn && !m_pd;
    st = (m_field != 0);
    nu = st && !me && ue && !de;
    nd = st && !me && de && !ue;
`ifdef SET_AUTOREPEAT_EN
    if (!st || me) m_rk = -1;
    else if ((ue && !down_btn) || (de && !up_btn)) begin
      m_rk = 0; m_dir = ue;
    end else if (m_rk >= 0 && (m_dir ? (up_btn && !down_btn) : (down_btn && !up_btn))) begin
      m_rk++;
      if (m_rk >= HOLD && (m_rk - HOLD) % RPT == 0) begin
        if (m_dir) nu = 1; else nd = 1;
      end
    end else m_rk = -1;
`endif
    clr = me || ue || de || up_btn || down_btn;
    if (me) begin
      m_field = (m_field + 1) % 7; m_idle = 0;
    end else if (!st || clr) m_idle = 0;
    else if (m_idle == TO - 1) begin
      m_field = 0; m_idle = 0;
    end else m_idle++;
    m_pm = mode_btn; m_pu = up_btn; m_pd = down_btn; m_arm = 1;
    m_up = nu; m_dn = nd;
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step();
    #1;
    chk("field_sel", 32'(field_sel), 32'(m_field));
    chk("setting",   32'(setting),   32'(m_field != 0));
    chk("set_up",    32'(set_up),    32'(m_up));
    chk("set_down",  32'(set_down),  32'(m_dn));
    chk("run_tick",  32'(run_tick),  32'(tick_en && m_field == 0));
  endtask

  task automatic press();
    mode_btn = 1; cyc();
    mode_btn = 0; cyc();
  endtask

  initial begin
    int n, nu, nd;
    int got_q[$];
    int exp_q[$];
    m_reset();

    // reset state, before any clock edge
    tick_en = 1;
    #2;
    chk("rst_field", 32'(field_sel), 0);
    chk("rst_setting", 32'(setting), 0);
    chk("rst_up", 32'(set_up), 0);
    chk("rst_dn", 32'(set_down), 0);
    chk("rst_run_tick", 32'(run_tick), 1);
    cyc(); cyc();
    rst = 0;
    cyc(); cyc();
    tick_en = 0;

    // full mode cycle from reset
    for (int i = 1; i <= 7; i++) begin
      press();
      chk("mode_seq", 32'(field_sel), 32'(i % 7));
      chk("mode_setting", 32'(setting), 32'(i % 7 != 0));
    end

    // YR: single up press, frozen time
    repeat (6) press();
    chk("yr_field", 32'(field_sel), 6);
    tick_en = 1; cyc();
    chk("yr_run_tick", 32'(run_tick), 0);
    tick_en = 0;
    up_btn = 1; cyc();
    chk("yr_up_latency", 32'(set_up), 1);
    nu = 1; nd = int'(set_down);
    up_btn = 0;
    repeat (5) begin
      cyc(); nu += int'(set_up); nd += int'(set_down);
    end
    chk("yr_up_count", 32'(nu), 1);
    chk("yr_dn_count", 32'(nd), 0);

    // MIN: simultaneous up+down, then mode+up
    repeat (3) press();
    chk("min_field", 32'(field_sel), 2);
    up_btn = 1; down_btn = 1; cyc();
    nu = int'(set_up) + int'(set_down);
    up_btn = 0; down_btn = 0;
    repeat (3) begin
      cyc(); nu += int'(set_up) + int'(set_down);
    end
    chk("updn_pulses", 32'(nu), 0);
    mode_btn = 1; up_btn = 1; cyc();
    nu = int'(set_up) + int'(set_down);
    mode_btn = 0; up_btn = 0;
    repeat (3) begin
      cyc(); nu += int'(set_up) + int'(set_down);
    end
    chk("mode_up_field", 32'(field_sel), 3);
    chk("mode_up_pulses", 32'(nu), 0);

    // idle timeout from SEC, then with a press at cycle 90
    repeat (4) press();
    chk("to_run", 32'(field_sel), 0);
    mode_btn = 1; cyc(); mode_btn = 0;
    n = 0;
    while (field_sel != 0 && n < 300) begin cyc(); n++; end
    chk("timeout_cycles", 32'(n), 100);
    mode_btn = 1; cyc(); mode_btn = 0;
    n = 0;
    repeat (89) begin cyc(); n++; end
    up_btn = 1; cyc(); n++; up_btn = 0;
    while (field_sel != 0 && n < 400) begin cyc(); n++; end
    chk("timeout_restart", 32'(n), 190);

    // DAY: hold up 40 cycles
    repeat (4) press();
    chk("day_field", 32'(field_sel), 4);
    up_btn = 1;
    for (int k = 0; k <= 43; k++) begin
      if (k == 41) up_btn = 0;
      cyc();
      if (set_up) got_q.push_back(k);
    end
`ifdef SET_AUTOREPEAT_EN
    exp_q = '{0, 20, 25, 30, 35, 40};
`else
    exp_q = '{0};
`endif
    chk("rpt_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("rpt_pos", 32'(got_q[i]), 32'(exp_q[i]));

    // MON: reset in the middle of a repeat
    press();
    chk("mon_field", 32'(field_sel), 5);
    up_btn = 1;
    for (int k = 0; k <= 25; k++) cyc();
    rst = 1; #1;
    chk("mid_rst_up", 32'(set_up), 0);
    chk("mid_rst_dn", 32'(set_down), 0);
    chk("mid_rst_field", 32'(field_sel), 0);
    chk("mid_rst_setting", 32'(setting), 0);
    m_reset();
    cyc(); cyc();
    rst = 0;
    cyc();
    mode_btn = 1; cyc(); mode_btn = 0;
    nu = 0;
    repeat (30) begin cyc(); nu += int'(set_up); end
    chk("held_after_rst", 32'(nu), 0);
    up_btn = 0; cyc();
    up_btn = 1; cyc();
    chk("repress_after_rst", 32'(set_up), 1);
    up_btn = 0; cyc(); cyc();

    // random phase
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) mode_btn = ~mode_btn;
      if ($urandom_range(0, 5) == 0) up_btn   = ~up_btn;
      if ($urandom_range(0, 5) == 0) down_btn = ~down_btn;
      tick_en = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 0; mode_btn = 0; up_btn = 0; down_btn = 0; tick_en = 0;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL provide parameter HOLD_CYC, default 50_000_000, cycles an up/down key must be held before auto-repeat starts.
REQ-002 SHALL provide parameter RPT_CYC, default 10_000_000, cycles between auto-repeat pulses.
REQ-003 SHALL provide parameter TIMEOUT_CYC, default 500_000_000, idle cycles in a set state before returning to RUN.
REQ-004 SHALL provide parameter CNT_W, default 32, width of the hold and timeout counters.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 tick_en  input  1  one-cycle 1 Hz timekeeping pulse from the prescaler.
REQ-008 mode_btn  input  1  debounced, synchronized mode key level.
REQ-009 up_btn  input  1  debounced, synchronized up key level.
REQ-010 down_btn  input  1  debounced, synchronized down key level.
REQ-011 run_tick  output  1  timekeeping enable forwarded to the seconds counter.
REQ-012 field_sel  output  3  selected field: 0 RUN, 1 sec, 2 min, 3 hour, 4 day, 5 month, 6 year.
REQ-013 set_up  output  1  one-cycle increment pulse to the selected counter's up input.
REQ-014 set_down  output  1  one-cycle decrement pulse to the selected counter's down input.
REQ-015 setting  output  1  high whenever field_sel is not 0.

Function
REQ-016 The block SHALL detect rising edges of mode_btn, up_btn, and down_btn by comparing each against a one-cycle-delayed register.
REQ-017 The FSM SHALL have states RUN, SEC, MIN, HOUR, DAY, MON, YR, encoded 0..6 and driven directly on field_sel.
REQ-018 On a mode edge, the FSM SHALL advance RUN->SEC->MIN->HOUR->DAY->MON->YR->RUN; codes 7 and above SHALL decode to RUN.
REQ-019 The new field_sel SHALL be visible one cycle after the clk edge that samples the mode edge.
REQ-020 run_tick SHALL equal tick_en (combinational) in RUN and SHALL be 0 in all set states, so time is frozen while setting.
REQ-021 In a set state, a lone up edge SHALL produce set_up high for exactly one cycle, registered, in the cycle after the edge is sampled; down edges SHALL behave the same on set_down.
REQ-022 Up and down edges arriving in the same cycle SHALL produce no pulse.
REQ-023 If a mode edge coincides with an up or down edge, the mode edge SHALL win and no pulse SHALL be issued.
REQ-024 In RUN, up and down edges SHALL be ignored.
REQ-025 set_up and set_down SHALL never be high in the same cycle.
REQ-026 The timeout counter SHALL clear on any key edge and while up_btn or down_btn is high, and SHALL otherwise increment in set states.
REQ-027 When the timeout counter reaches TIMEOUT_CYC-1, the FSM SHALL return to RUN on the next edge and the counter SHALL clear.
REQ-028 In RUN, the timeout counter SHALL be held at 0.

Reset
REQ-029 While rst is high, the block SHALL force state RUN, field_sel=0, setting=0, set_up=0, set_down=0, all counters to 0, and edge registers to 0; run_tick=tick_en.
REQ-030 A reset asserted mid-set or mid-repeat SHALL abort immediately with no further pulse.
REQ-031 A key already held when rst deasserts SHALL NOT count as an edge until it is released and pressed again.

Configuration
REQ-032 With macro SET_AUTOREPEAT_EN defined, holding exactly one of up_btn/down_btn in a set state SHALL start the hold counter at the press edge.
REQ-033 With SET_AUTOREPEAT_EN defined, after HOLD_CYC cycles the block SHALL emit one pulse, then one pulse every RPT_CYC cycles until release, when both keys are held, or on a state change, which clears the counter.
REQ-034 Without SET_AUTOREPEAT_EN, the hold counter SHALL be absent and only press edges SHALL generate pulses.

Verification
REQ-035 Bench: 7 mode presses from reset -> field_sel 1,2,3,4,5,6,0; setting low only at 0.
REQ-036 Bench: state YR, one up press -> exactly one set_up cycle, one cycle after the edge; set_down stays 0; tick_en pulses give run_tick=0.
REQ-037 Bench: state MIN, up and down pressed in the same cycle -> no pulses; mode+up in the same cycle -> field_sel=3 and no pulse.
REQ-038 Bench: TIMEOUT_CYC=100, enter SEC and go idle -> field_sel returns to 0 after 100 cycles; a press at cycle 90 restarts the count.
REQ-039 Bench: SET_AUTOREPEAT_EN, HOLD_CYC=20, RPT_CYC=5, up held 40 cycles in DAY -> pulses at the press edge, at +20, and at +25/+30/+35/+40; none without the macro beyond the first.
REQ-040 Bench: rst pulsed during repeat in MON -> outputs 0 at once, field_sel=0; the held key produces no pulse after release of rst.
